mips_multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS core.
- Decodes the IR opcode field and sequences fetch, decode, execute, memory and writeback.
- Drives all datapath enables and produces the 3-bit ALUOp consumed by the ALU control decoder, which resolves funct fields only when ALUOp = 111.
- Holds off on a memory ready handshake and flags memory timeouts and illegal opcodes.

---
 rtl/mips_multicycle_control.sv | 157 +++++++++++++++
 tb/tb_mips_multicycle_control.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS main control FSM with memory handshake,
// memory watchdog and illegal-opcode detection.
module mips_multicycle_control #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_o
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    R_EX, ALU_WB, I_EX, I_WB, BRANCH, JUMP
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
    OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
    OP_LW = 6'b100011, OP_SW = 6'b101011, OP_J = 6'b000010, OP_JAL = 6'b000011;
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic waiting, expire;
  assign waiting = (state == FETCH || state == MEMRD || state == MEMWR) && !mem_ready;
  assign expire = TIMEOUT != 0 && waiting && cnt == CNT_W'(TIMEOUT - 1);
  assign state_o = state;
  // Counter restarts on every state change, so it only measures the current wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= next;
      cnt <= next != state ? '0 : waiting ? cnt + 1'b1 : cnt;
      if (expire) bus_error <= 1'b1;
    end
  end
  always_comb begin
    next = state;
    pc_write = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 2'b00;
    mem_to_reg = 2'b00;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    pc_src = 2'b00;
    alu_op = 3'b000;
    illegal_op = 1'b0;
    case (state)
      IDLE: next = FETCH;
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'b01;
        alu_op = 3'b100;
        ir_write = mem_ready;
        pc_write = mem_ready;
        next = expire ? IDLE : mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op = 3'b100;
        case (opcode)
          OP_R: next = R_EX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next = I_EX;
          OP_LW, OP_SW: next = MEMADR;
          OP_BEQ, OP_BNE: next = BRANCH;
          OP_J, OP_JAL: next = JUMP;
          default: begin
            next = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      R_EX: begin
        alu_src_a = 1'b1;
        alu_op = 3'b111;
        next = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        reg_dst = 2'b01;
        next = FETCH;
      end
      I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = opcode == OP_ANDI ? 3'b110 : opcode == OP_ORI ? 3'b101 :
                 opcode == OP_LUI ? 3'b011 : 3'b100;
        next = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        next = FETCH;
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op = 3'b100;
        next = opcode == OP_SW ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        mem_read = 1'b1;
        next = expire ? IDLE : mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write = 1'b1;
        mem_to_reg = 2'b01;
        next = FETCH;
      end
      MEMWR: begin
        iord = 1'b1;
        mem_write = 1'b1;
        next = expire ? IDLE : mem_ready ? FETCH : MEMWR;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = 3'b001;
        pc_src = 2'b01;
        branch_eq = opcode == OP_BEQ;
        branch_ne = opcode == OP_BNE;
        next = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src = 2'b10;
        reg_write = opcode == OP_JAL;
        reg_dst = opcode == OP_JAL ? 2'b10 : 2'b00;
        mem_to_reg = opcode == OP_JAL ? 2'b10 : 2'b00;
        next = FETCH;
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: random instruction stream with random memory stalls,
// each instruction modelled as a string of phases; a negedge monitor scores every cycle.
module tb_mips_multicycle_control;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic reg_write, alu_src_a, illegal_op, bus_error;
  logic [2:0] alu_op;
  logic [3:0] state_o;
  always #5 clk = ~clk;
  mips_multicycle_control #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch_eq(branch_eq), .branch_ne(branch_ne), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op), .illegal_op(illegal_op),
    .bus_error(bus_error), .state_o(state_o)
  );
  typedef struct packed {
    logic pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic illegal_op, bus_error, idle;
  } vec_t;
  vec_t exp_q[$];
  byte tag_q[$];
  int checks = 0, passes = 0;
  logic [5:0] legal [11] = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h04, 6'h05,
                             6'h23, 6'h2b, 6'h02, 6'h03};
  // Phases: F fetch, D decode, X illegal decode, R/A R-type, I/W immediate,
  // M address, L/B load, S store, Q branch, J jump.
  function automatic string prog_of(logic [5:0] op);
    case (op)
      6'h00: return "FDRA";
      6'h08, 6'h0c, 6'h0d, 6'h0f: return "FDIW";
      6'h23: return "FDMLB";
      6'h2b: return "FDMS";
      6'h04, 6'h05: return "FDQ";
      6'h02, 6'h03: return "FDJ";
      default: return "FX";
    endcase
  endfunction
  function automatic vec_t expect_of(byte ph, logic [5:0] op, logic mr);
    vec_t v = '0;
    case (ph)
      "F": begin v.mem_read = 1; v.alu_src_b = 2'b01; v.alu_op = 3'b100; v.ir_write = mr; v.pc_write = mr; end
      "D", "X": begin v.alu_src_b = 2'b11; v.alu_op = 3'b100; v.illegal_op = ph == "X"; end
      "R": begin v.alu_src_a = 1; v.alu_op = 3'b111; end
      "A": begin v.reg_write = 1; v.reg_dst = 2'b01; end
      "I": begin
        v.alu_src_a = 1; v.alu_src_b = 2'b10;
        v.alu_op = op == 6'h0c ? 3'b110 : op == 6'h0d ? 3'b101 : op == 6'h0f ? 3'b011 : 3'b100;
      end
      "W": v.reg_write = 1;
      "M": begin v.alu_src_a = 1; v.alu_src_b = 2'b10; v.alu_op = 3'b100; end
      "L": begin v.iord = 1; v.mem_read = 1; end
      "B": begin v.reg_write = 1; v.mem_to_reg = 2'b01; end
      "S": begin v.iord = 1; v.mem_write = 1; end
      "Q": begin
        v.alu_src_a = 1; v.alu_op = 3'b001; v.pc_src = 2'b01;
        v.branch_eq = op == 6'h04; v.branch_ne = op == 6'h05;
      end
      "J": begin
        v.pc_write = 1; v.pc_src = 2'b10;
        if (op == 6'h03) begin v.reg_write = 1; v.reg_dst = 2'b10; v.mem_to_reg = 2'b10; end
      end
      default: v.idle = 1;
    endcase
    return v;
  endfunction
  initial begin
    string prog = "";
    int pos = 0, wcnt = 0, stall = 0;
    bit idle = 1, berr = 0, start = 0;
    byte ph;
    vec_t e;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      if (start) begin
        opcode = $urandom_range(99) < 85 ? legal[$urandom_range(10)] : 6'($urandom);
        prog = prog_of(opcode);
        pos = 0;
        wcnt = 0;
        start = 0;
      end
      if (stall > 0) begin
        mem_ready = 1'b0;
        stall--;
      end else if ($urandom_range(99) < 3) begin
        mem_ready = 1'b0;
        stall = 5;
      end else mem_ready = $urandom_range(99) < 70;
      if (cyc % 700 == 350) begin
        reset = 1'b0;
        ph = "-";
        e = expect_of(ph, opcode, mem_ready);
        idle = 1;
        berr = 0;
      end else if (idle) begin
        ph = "-";
        e = expect_of(ph, opcode, mem_ready);
        e.bus_error = berr;
        idle = 0;
        start = 1;
      end else begin
        ph = prog[pos];
        e = expect_of(ph, opcode, mem_ready);
        e.bus_error = berr;
        if ((ph == "F" || ph == "L" || ph == "S") && !mem_ready) begin
          wcnt++;
          if (wcnt == TO) begin
            berr = 1;
            idle = 1;
          end
        end else if (pos + 1 < prog.len()) begin
          pos++;
          wcnt = 0;
        end else start = 1;
      end
      exp_q.push_back(e);
      tag_q.push_back(ph);
    end
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      vec_t a, e;
      byte t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {pc_write, branch_eq, branch_ne, iord, mem_read, mem_write, ir_write, reg_dst,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src, alu_op, illegal_op,
           bus_error, state_o == 4'd0};
      checks++;
      if (a === e) passes++;
      else $display("FAIL outputs phase=%c opcode=%h mem_ready=%b got=%h required=%h",
                    t, opcode, mem_ready, a, e);
    end
  end
endmodule
